// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl
// ---------------------
// Multi-cycle main control FSM for the LEGv8 core. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and handshakes with the
// instruction and data memories through ready signals. Memory waits are
// bounded by MEM_TIMEOUT cycles. An undecodable opcode or an expired wait
// parks the FSM in a sticky ERR state, and only rst leaves that state.
//
// Parameters
//   MEM_TIMEOUT : cycles to wait for imem_ready/dmem_ready before ERR (1..255)
//   EN_EXT      : 1 = CBNZ/B/ADDI are legal, 0 = they decode as illegal
//
// Ports
//   clk, rst              : clock and synchronous active-high reset
//   insOp[10:0]           : IR[31:21], the opcode field
//   zero                  : ALU zero flag, used in EXEC for CBZ/CBNZ
//   imem_ready/dmem_ready : memory done strobes, sampled in FETCH/MEM
//   imem_req, ir_write    : fetch request and IR latch pulse
//   pc_write, pc_src      : PC load and select (1 = branch target)
//   Reg2Loc, AluSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite
//                         : datapath controls
//   retire                : one-cycle pulse per completed instruction
//   illegal               : high while in ERR
//   state[2:0]            : current FSM state, for debug
module legv8_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_EXT      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] insOp,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        Reg2Loc,
  output logic        AluSrc,
  output logic [1:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } stateT;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_B, CLS_ADDI
  } insClassT;

  // The counter holds the number of cycles already spent waiting, so the
  // last allowed wait cycle is the one where it equals MEM_TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  stateT    curState, nextState;
  insClassT insClass, decClass;
  logic [7:0] waitCnt;

  assign state = curState;

  // Opcode classifier. The patterns do not overlap, so their order does not matter.
  always_comb begin
    decClass = CLS_NONE;
    casez (insOp)
      11'b1??0101?000: decClass = CLS_R;
      11'b11111000010: decClass = CLS_LDUR;
      11'b11111000000: decClass = CLS_STUR;
      11'b10110100???: decClass = CLS_CBZ;
      11'b10110101???: if (EN_EXT) decClass = CLS_CBNZ;
      11'b000101?????: if (EN_EXT) decClass = CLS_B;
      11'b1001000100?: if (EN_EXT) decClass = CLS_ADDI;
      default:         decClass = CLS_NONE;
    endcase
  end

  // NOTE: reset is synchronous (sampled at the clock edge), and it wins over every state including ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= IDLE;
      insClass <= CLS_NONE;
      waitCnt  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
      curState <= nextState;
      if (curState == DECODE) insClass <= decClass;
      // The counter runs only while a memory wait continues. Any exit from
      // FETCH/MEM (ready, timeout) clears it for the next wait.
      if ((curState == FETCH || curState == MEM) && nextState == curState)
        waitCnt <= waitCnt + 8'd1;
      else
        waitCnt <= '0;
    end
  end

  always_comb begin
    // NOTE: every output and nextState gets a default first, so no path infers a latch.
    nextState = curState;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    Reg2Loc   = 1'b0;
    AluSrc    = 1'b0;
    ALUOp     = 2'b00;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    unique case (curState)
      IDLE: nextState = FETCH;

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;        // PC+4, pc_src stays 0
          nextState = DECODE;
        end else if (waitCnt == LAST_WAIT) begin
          nextState = ERR;
        end
      end

      DECODE: nextState = (decClass == CLS_NONE) ? ERR : EXEC;

      EXEC: begin
        unique case (insClass)
          CLS_R: begin
            ALUOp     = 2'b10;
            nextState = WB;
          end
          CLS_ADDI: begin
            AluSrc    = 1'b1;
            ALUOp     = 2'b11;
            nextState = WB;
          end
          CLS_LDUR, CLS_STUR: begin
            AluSrc    = 1'b1;
            Reg2Loc   = (insClass == CLS_STUR);
            nextState = MEM;
          end
          CLS_CBZ, CLS_CBNZ: begin
            Reg2Loc   = 1'b1;
            ALUOp     = 2'b01;
            // CBZ branches on zero and CBNZ on not-zero. pc_src is raised only when the branch is taken.
            pc_write  = (insClass == CLS_CBZ) ? zero : !zero;
            pc_src    = pc_write;
            retire    = 1'b1;
            nextState = FETCH;
          end
          CLS_B: begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            retire    = 1'b1;
            nextState = FETCH;
          end
          default: nextState = ERR;  // no valid class latched
        endcase
      end

      MEM: begin
        AluSrc = 1'b1;
        if (insClass == CLS_STUR) begin
          Reg2Loc  = 1'b1;
          MemWrite = 1'b1;
        end else begin
          MemRead  = 1'b1;
        end
        if (dmem_ready) begin
          retire    = (insClass == CLS_STUR);
          nextState = (insClass == CLS_STUR) ? FETCH : WB;
        end else if (waitCnt == LAST_WAIT) begin
          nextState = ERR;
        end
      end

      WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = (insClass == CLS_LDUR);
        retire    = 1'b1;
        nextState = FETCH;
      end

      ERR: illegal = 1'b1;

      default: nextState = ERR;  // unused encoding 6
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl. Instance dut has the extended
// opcodes enabled (EN_EXT=1). Instance dutNoExt has them disabled
// (EN_EXT=0). The two instances share clk, zero and both ready strobes.
// Each instance has its own rst and insOp. Outputs are packed into a
// 14-bit control word and compared with hand-written constants:
//   {imem_req, ir_write, pc_write, pc_src, Reg2Loc, AluSrc, ALUOp[1:0],
//    MemRead, MemWrite, MemtoReg, RegWrite, retire, illegal}
module tb_legv8_multicycle_ctrl;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_BAD   = 11'b00000000000;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd7;

  //                                         req ir pcw pcs r2l as op  mr mw m2r rw ret ill
  localparam logic [13:0] C_NONE       = 14'b0000_0000_0000_00;
  localparam logic [13:0] C_FETCH_RDY  = 14'b1110_0000_0000_00;
  localparam logic [13:0] C_FETCH_WAIT = 14'b1000_0000_0000_00;
  localparam logic [13:0] C_R_EXEC     = 14'b0000_0010_0000_00;
  localparam logic [13:0] C_ADDI_EXEC  = 14'b0000_0111_0000_00;
  localparam logic [13:0] C_LD_EXEC    = 14'b0000_0100_0000_00;
  localparam logic [13:0] C_ST_EXEC    = 14'b0000_1100_0000_00;
  localparam logic [13:0] C_LD_MEM     = 14'b0000_0100_1000_00;
  localparam logic [13:0] C_ST_MEM_RDY = 14'b0000_1100_0100_10;
  localparam logic [13:0] C_WB_ALU     = 14'b0000_0000_0001_10;
  localparam logic [13:0] C_WB_LD      = 14'b0000_0000_0011_10;
  localparam logic [13:0] C_CB_TAKEN   = 14'b0011_1001_0000_10;
  localparam logic [13:0] C_CB_NOT     = 14'b0000_1001_0000_10;
  localparam logic [13:0] C_B_EXEC     = 14'b0011_0000_0000_10;
  localparam logic [13:0] C_ERR        = 14'b0000_0000_0000_01;

  logic clk = 1'b0;
  logic rst, rstX, zero, imemReady, dmemReady;
  logic [10:0] insOp, insOpX;

  logic imemReq, irWrite, pcWrite, pcSrc, reg2Loc, aluSrc, memRead, memWrite,
        memToReg, regWrite, retire, illegal;
  logic [1:0] aluOp;
  logic [2:0] state;
  logic imemReqX, irWriteX, pcWriteX, pcSrcX, reg2LocX, aluSrcX, memReadX,
        memWriteX, memToRegX, regWriteX, retireX, illegalX;
  logic [1:0] aluOpX;
  logic [2:0] stateX;
  logic [13:0] ctrl, ctrlX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(16), .EN_EXT(1'b1)) dut (
    .clk(clk), .rst(rst), .insOp(insOp), .zero(zero),
    .imem_ready(imemReady), .dmem_ready(dmemReady),
    .imem_req(imemReq), .ir_write(irWrite), .pc_write(pcWrite), .pc_src(pcSrc),
    .Reg2Loc(reg2Loc), .AluSrc(aluSrc), .ALUOp(aluOp), .MemRead(memRead),
    .MemWrite(memWrite), .MemtoReg(memToReg), .RegWrite(regWrite),
    .retire(retire), .illegal(illegal), .state(state)
  );

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(16), .EN_EXT(1'b0)) dutNoExt (
    .clk(clk), .rst(rstX), .insOp(insOpX), .zero(zero),
    .imem_ready(imemReady), .dmem_ready(dmemReady),
    .imem_req(imemReqX), .ir_write(irWriteX), .pc_write(pcWriteX), .pc_src(pcSrcX),
    .Reg2Loc(reg2LocX), .AluSrc(aluSrcX), .ALUOp(aluOpX), .MemRead(memReadX),
    .MemWrite(memWriteX), .MemtoReg(memToRegX), .RegWrite(regWriteX),
    .retire(retireX), .illegal(illegalX), .state(stateX)
  );

  assign ctrl  = {imemReq, irWrite, pcWrite, pcSrc, reg2Loc, aluSrc, aluOp,
                  memRead, memWrite, memToReg, regWrite, retire, illegal};
  assign ctrlX = {imemReqX, irWriteX, pcWriteX, pcSrcX, reg2LocX, aluSrcX, aluOpX,
                  memReadX, memWriteX, memToRegX, regWriteX, retireX, illegalX};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then wait until the outputs have settled.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect1(input string tag, input logic [2:0] st, input logic [13:0] c);
    #1;
    check({tag, ".state"}, {29'd0, state}, {29'd0, st});
    check({tag, ".ctrl"},  {18'd0, ctrl},  {18'd0, c});
  endtask

  task automatic expect2(input string tag, input logic [2:0] st, input logic [13:0] c);
    #1;
    check({tag, ".state"}, {29'd0, stateX}, {29'd0, st});
    check({tag, ".ctrl"},  {18'd0, ctrlX},  {18'd0, c});
  endtask

  initial begin
    rst = 1'b1; rstX = 1'b1; insOp = OP_ADD; insOpX = OP_B;
    zero = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;

    // Reset held two cycles, then released with imem_ready already high.
    step(); step();
    expect1("rst", S_IDLE, C_NONE);
    imemReady = 1'b1;
    rst = 1'b0;
    expect1("idle", S_IDLE, C_NONE);

    // ADD: FETCH, DECODE, EXEC, WB, then back to FETCH.
    step(); expect1("add.fetch",  S_FETCH,  C_FETCH_RDY);
    step(); expect1("add.decode", S_DECODE, C_NONE);
    step(); expect1("add.exec",   S_EXEC,   C_R_EXEC);
    step(); expect1("add.wb",     S_WB,     C_WB_ALU);

    // LDUR: dmem_ready comes in the fourth MEM cycle.
    step(); insOp = OP_LDUR; expect1("ld.fetch", S_FETCH, C_FETCH_RDY);
    step(); expect1("ld.decode", S_DECODE, C_NONE);
    step(); expect1("ld.exec",   S_EXEC,   C_LD_EXEC);
    step();
    for (int i = 0; i < 3; i++) begin
      expect1("ld.memwait", S_MEM, C_LD_MEM);
      step();
    end
    dmemReady = 1'b1;
    expect1("ld.memrdy", S_MEM, C_LD_MEM);
    step(); dmemReady = 1'b0;
    expect1("ld.wb", S_WB, C_WB_LD);

    // CBNZ with zero=0 is taken.
    step(); insOp = OP_CBNZ; zero = 1'b0; expect1("cbnz0.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("cbnz0.exec", S_EXEC, C_CB_TAKEN);
    // CBNZ with zero=1 is not taken.
    step(); zero = 1'b1; expect1("cbnz1.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("cbnz1.exec", S_EXEC, C_CB_NOT);
    // CBZ with zero=1 is taken.
    step(); insOp = OP_CBZ; expect1("cbz1.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("cbz1.exec", S_EXEC, C_CB_TAKEN);
    // CBZ with zero=0 is not taken.
    step(); zero = 1'b0; expect1("cbz0.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("cbz0.exec", S_EXEC, C_CB_NOT);
    // B
    step(); insOp = OP_B; expect1("b.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("b.exec", S_EXEC, C_B_EXEC);
    // ADDI
    step(); insOp = OP_ADDI; expect1("addi.fetch", S_FETCH, C_FETCH_RDY);
    step(); step(); expect1("addi.exec", S_EXEC, C_ADDI_EXEC);
    step(); expect1("addi.wb", S_WB, C_WB_ALU);
    // STUR with a zero-wait data memory: 4 cycles, retire in MEM.
    step(); insOp = OP_STUR; dmemReady = 1'b1; expect1("st.fetch", S_FETCH, C_FETCH_RDY);
    step(); expect1("st.decode", S_DECODE, C_NONE);
    step(); expect1("st.exec",   S_EXEC,   C_ST_EXEC);
    step(); expect1("st.mem",    S_MEM,    C_ST_MEM_RDY);
    step(); dmemReady = 1'b0; imemReady = 1'b0;

    // Fetch timeout: 16 FETCH cycles without ready, then ERR.
    for (int i = 0; i < 16; i++) begin
      expect1("to.fetch", S_FETCH, C_FETCH_WAIT);
      step();
    end
    expect1("to.err", S_ERR, C_ERR);
    imemReady = 1'b1;
    step(); step(); step();
    expect1("to.sticky", S_ERR, C_ERR);
    rst = 1'b1;
    step(); expect1("to.rst", S_IDLE, C_NONE);

    // An undecodable opcode goes to ERR from DECODE.
    rst = 1'b0; insOp = OP_BAD;
    step(); expect1("bad.fetch",  S_FETCH,  C_FETCH_RDY);
    step(); expect1("bad.decode", S_DECODE, C_NONE);
    step(); expect1("bad.err",    S_ERR,    C_ERR);

    // EN_EXT=0: B is illegal.
    rstX = 1'b0;
    expect2("nx.idle", S_IDLE, C_NONE);
    step(); expect2("nxb.fetch",  S_FETCH,  C_FETCH_RDY);
    step(); expect2("nxb.decode", S_DECODE, C_NONE);
    step(); expect2("nxb.err",    S_ERR,    C_ERR);
    step(); expect2("nxb.sticky", S_ERR,    C_ERR);
    // EN_EXT=0: ADDI is illegal too.
    rstX = 1'b1; step(); rstX = 1'b0; insOpX = OP_ADDI;
    expect2("nxa.idle", S_IDLE, C_NONE);
    step(); step(); step(); expect2("nxa.err", S_ERR, C_ERR);
    // EN_EXT=0: STUR is still legal and never asserts RegWrite.
    rstX = 1'b1; step(); rstX = 1'b0; insOpX = OP_STUR; dmemReady = 1'b1;
    expect2("nxs.idle", S_IDLE, C_NONE);
    step(); expect2("nxs.fetch",  S_FETCH,  C_FETCH_RDY);
    step(); expect2("nxs.decode", S_DECODE, C_NONE);
    step(); expect2("nxs.exec",   S_EXEC,   C_ST_EXEC);
    step(); expect2("nxs.mem",    S_MEM,    C_ST_MEM_RDY);
    step(); expect2("nxs.fetch2", S_FETCH,  C_FETCH_RDY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
